div_unit: RTL and testbench

// - Multi-cycle iterative divider: the responder side of the EX-stage divide handshake (div_en in; done and result_div out).
// - Executes MIPS DIV (signed) and DIVU (unsigned) with radix-2 restoring division.
// - Returns {remainder, quotient}; EX forwards it to the HILO stage (HI = remainder, LO = quotient).
// - EX holds the pipeline stalled until done is asserted.

---
 rtl/div_unit_pkg.sv | 15 +
 rtl/div_unit_step.sv | 24 ++
 rtl/div_unit.sv | 113 +++++++++++
 tb/tb_div_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: MIPS funct codes and FSM state encoding.
package div_unit_pkg;

  localparam int FUNCT_W = 6;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV  = 6'b011010;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division step on a packed {rem, quo} pair.
module div_unit_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] rq_in,
  input  logic [DATA_WIDTH-1:0]   divisor,
  output logic [2*DATA_WIDTH-1:0] rq_out
);

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;

  always_comb begin
    // Carry bit keeps the trial compare exact when the divisor uses the top bit.
    shifted = rq_in[2*DATA_WIDTH-1:DATA_WIDTH-1];
    diff    = shifted[DATA_WIDTH-1:0] - divisor;
    if (shifted >= {1'b0, divisor}) begin
      rq_out = {diff, rq_in[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rq_out = {shifted[DATA_WIDTH-1:0], rq_in[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU; result is {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN skips the loop for zero divisor or |op1| < |op2|.
// Handshake: div_en is sampled only in IDLE; done pulses for one cycle with result_div
// valid in that cycle; flush aborts any active operation and gates done the same cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [FUNCT_W-1:0]      funct,
  input  logic                    div_en,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   operand_1,
  input  logic [DATA_WIDTH-1:0]   operand_2,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] result_div,
  output logic                    busy,
  output div_state_e              state_dbg
);

  localparam int STEPS = DATA_WIDTH / RADIX_BITS;
  localparam int CNT_W = $clog2(STEPS) + 1;

  div_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  sign_q, sign_r;

  logic                  is_signed, neg1, neg2, start, early;
  logic [DATA_WIDTH-1:0] mag1, mag2, rem_fix, quo_fix;
  logic [2*DATA_WIDTH-1:0] chain [RADIX_BITS+1];

  assign is_signed = (funct == FUNCT_DIV);
  assign neg1      = is_signed & operand_1[DATA_WIDTH-1];
  assign neg2      = is_signed & operand_2[DATA_WIDTH-1];
  assign mag1      = neg1 ? (~operand_1 + 1'b1) : operand_1;
  assign mag2      = neg2 ? (~operand_2 + 1'b1) : operand_2;
  assign start     = (state_q == DIV_IDLE) && div_en && !flush;

`ifdef DIV_EARLY_OUT_EN
  assign early = (mag2 == '0) || (mag1 < mag2);
`else
  assign early = 1'b0;
`endif

  assign chain[0] = {rem_q, quo_q};
  for (genvar g = 0; g < RADIX_BITS; g++) begin : g_step
    div_unit_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .rq_in  (chain[g]),
      .divisor(dvsr_q),
      .rq_out (chain[g+1])
    );
  end

  assign rem_fix = sign_r ? (~rem_q + 1'b1) : rem_q;
  assign quo_fix = sign_q ? (~quo_q + 1'b1) : quo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start) state_d = early ? DIV_FIX : DIV_BUSY;
      DIV_BUSY: begin
        if (flush)                      state_d = DIV_IDLE;
        else if (cnt_q == CNT_W'(1))    state_d = DIV_FIX;
      end
      DIV_FIX:  state_d = flush ? DIV_IDLE : DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      result_div <= '0;
    end else begin
      if (start) begin
        // Early-out preloads the final answer: quotient 0, remainder = |dividend|.
        rem_q  <= early ? mag1 : '0;
        quo_q  <= early ? '0 : mag1;
        dvsr_q <= mag2;
        cnt_q  <= CNT_W'(STEPS);
        sign_q <= neg1 ^ neg2;
        sign_r <= neg1;
      end else if (state_q == DIV_BUSY && !flush) begin
        {rem_q, quo_q} <= chain[RADIX_BITS];
        cnt_q          <= cnt_q - CNT_W'(1);
      end
      if (state_q == DIV_FIX && !flush) begin
        result_div <= {rem_fix, quo_fix};
      end
    end
  end

  assign done      = (state_q == DIV_DONE) && !flush;
  assign busy      = (state_q == DIV_BUSY) || (state_q == DIV_FIX);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: results, latency, flush, back-to-back and reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [FUNCT_W-1:0] funct;
  logic               div_en;
  logic               flush;
  logic [31:0]        operand_1, operand_2;
  logic               done;
  logic [63:0]        result_div;
  logic               busy;
  div_state_e         state_dbg;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_exp;

  localparam int LAT_FULL = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_ZERO = 1;
  localparam logic [63:0] RES_DIVU_5_0 = {32'd5, 32'd0};
  localparam logic [63:0] RES_UBIG     = {32'h8000_0000, 32'd0};
  localparam int LAT_UBIG = 1;
`else
  localparam int LAT_ZERO = 33;
  localparam logic [63:0] RES_DIVU_5_0 = {32'd5, 32'hFFFF_FFFF};
  localparam logic [63:0] RES_UBIG     = {32'h8000_0000, 32'd0};
  localparam int LAT_UBIG = 33;
`endif

  always #5 clk = ~clk;

  div_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .funct     (funct),
    .div_en    (div_en),
    .flush     (flush),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .done      (done),
    .result_div(result_div),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One operation: capture edge, wait for done (bounded), check latency, busy span and result.
  task automatic run_div(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    int busy_cnt;
    @(negedge clk);
    funct = f; operand_1 = a; operand_2 = b; div_en = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, "_res"}, result_div, exp_res);
    last_exp = exp_res;
    @(negedge clk);
    div_en = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int n;
    int pulses;
    int first_at;
    int second_at;

    rst_n = 1'b0; funct = FUNCT_DIVU; div_en = 1'b0; flush = 1'b0;
    operand_1 = '0; operand_2 = '0; last_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_res", result_div, 64'd0);
    check("rst_state", 64'(state_dbg), 64'(DIV_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    run_div("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, LAT_FULL);
    run_div("div_m7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, LAT_FULL);
    run_div("div_7_m2", FUNCT_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, LAT_FULL);
    run_div("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, LAT_FULL);
    run_div("divu_5_0", FUNCT_DIVU, 32'd5, 32'd0, RES_DIVU_5_0, LAT_ZERO);
    run_div("divu_max_1", FUNCT_DIVU, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, LAT_FULL);
    run_div("divu_big", FUNCT_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, RES_UBIG, LAT_UBIG);

    // Flush mid-BUSY: back to IDLE next edge, no result update.
    @(negedge clk);
    funct = FUNCT_DIVU; operand_1 = 32'd1000; operand_2 = 32'd3; div_en = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; div_en = 1'b0;
    #1;
    check("flush_done_gated", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    check("flush_state", 64'(state_dbg), 64'(DIV_IDLE));
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_res", result_div, last_exp);
    @(negedge clk);
    flush = 1'b0;
    run_div("divu_9_3", FUNCT_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, LAT_FULL);

    // Back-to-back with div_en held: DONE ignores the request, IDLE re-samples it.
    @(negedge clk);
    funct = FUNCT_DIV; operand_1 = 32'd20; operand_2 = 32'd3; div_en = 1'b1;
    n = 0; pulses = 0; first_at = 0; second_at = 0;
    while (pulses < 2 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          first_at = n;
          check("b2b_res1", result_div, {32'd2, 32'd6});
          operand_1 = 32'hFFFF_FFEC;
        end else begin
          second_at = n;
          check("b2b_res2", result_div, {32'hFFFF_FFFE, 32'hFFFF_FFFA});
        end
      end
    end
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_first", 64'(first_at), 64'd34);
    check("b2b_gap", 64'(second_at - first_at), 64'd35);
    @(negedge clk);
    div_en = 1'b0;

    // Asynchronous reset mid-BUSY.
    @(negedge clk);
    funct = FUNCT_DIVU; operand_1 = 32'd100; operand_2 = 32'd7; div_en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_res", result_div, 64'd0);
    check("arst_state", 64'(state_dbg), 64'(DIV_IDLE));
    div_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_div("post_rst_divu", FUNCT_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, LAT_FULL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
